// File: rtl/input_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : input_conditioner_pkg
// Description : Shared constants and helper functions for the input conditioner.
// Revision    : 1.0
// ============================================================================
package input_conditioner_pkg;

    // Ceiling log2; clog2(1) returns 0.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/input_conditioner_channel.sv
`default_nettype none
// ============================================================================
// Module      : input_channel
// Description : One-bit synchroniser, debouncer, edge pulses and sticky request.
// Revision    : 1.0
// ============================================================================
module input_channel
    import input_conditioner_pkg::*;
#(
    parameter int NSYNC           = 2,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic in,
    input  logic req_clear,
    output logic level,
    output logic rise,
    output logic fall,
    output logic req_pending
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NSYNC-1:0] r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             w_s;
    logic             w_accept;
    logic             w_set;

    assign w_s      = r_sync[NSYNC-1];
    assign w_accept = (w_s != level) && (r_cnt == c_cnt_last);
    assign w_set    = w_accept && w_s;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[NSYNC-2:0], in};
        end
    end

    // Any return of the synchronised input to the accepted level restarts the count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (w_s == level) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= '0;
                level <= w_s;
                rise  <= w_s;
                fall  <= ~w_s;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // A new rise takes priority over a coincident clear so no request is lost.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_pending <= 1'b0;
        end else if (w_set) begin
            req_pending <= 1'b1;
        end else if (req_clear) begin
            req_pending <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : input_conditioner
// Description : NCH independent conditioned inputs for the traffic controller.
// Revision    : 1.0
// ============================================================================
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int NCH             = 4,
    parameter int NSYNC           = 2,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic [NCH-1:0] in,
    input  logic [NCH-1:0] req_clear,
    output logic [NCH-1:0] level,
    output logic [NCH-1:0] rise,
    output logic [NCH-1:0] fall,
    output logic [NCH-1:0] req_pending
);

    localparam int CNT_W = clog2(DEBOUNCE_CYCLES) + 1;

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        input_channel #(
            .NSYNC           (NSYNC),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_channel (
            .clock       (clock),
            .reset_n     (reset_n),
            .in          (in[ch]),
            .req_clear   (req_clear[ch]),
            .level       (level[ch]),
            .rise        (rise[ch]),
            .fall        (fall[ch]),
            .req_pending (req_pending[ch])
        );
    end

endmodule
`default_nettype wire
